// File: rtl/frac_clk_div_if.sv
// Config write channel for frac_clk_div: valid/ready handshake carrying the target channel and increment.
// When FRAC_DIV_PHASE_EN is defined the channel also carries cfg_phase.
interface frac_clk_div_if #(
  parameter int NUM_CH = 2,
  parameter int ACC_W  = 32
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_ch;
  logic [ACC_W-1:0] cfg_inc;

`ifdef FRAC_DIV_PHASE_EN
  logic [ACC_W-1:0] cfg_phase;

  modport master (
    output cfg_valid, cfg_ch, cfg_inc, cfg_phase,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_ch, cfg_inc, cfg_phase,
    output cfg_ready
  );
`else
  modport master (
    output cfg_valid, cfg_ch, cfg_inc,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_ch, cfg_inc,
    output cfg_ready
  );
`endif
endinterface

// File: rtl/frac_clk_div.sv
// Multi-channel fractional clock-enable generator: per-channel phase accumulators give a wrap tick and an
// MSB divided clock; a shared settle FSM raises locked. Define FRAC_DIV_PHASE_EN for programmable write phase.
module frac_clk_div #(
  parameter int               NUM_CH        = 2,
  parameter int               ACC_W         = 32,
  parameter logic [ACC_W-1:0] INIT_INC      = 32'h4000_0000,
  parameter int               SETTLE_CYCLES = 16
) (
  input  logic              refclk,
  input  logic              rst,
  frac_clk_div_if.slave     cfg,
  output logic [NUM_CH-1:0] outclk,
  output logic [NUM_CH-1:0] tick,
  output logic              locked
);

  localparam int CNT_W = $clog2(SETTLE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_HOLD   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_LOCKED = 2'd2
  } lock_state_e;

  logic              ready_q;
  logic              accept;
  logic              wr_en;
  logic [NUM_CH-1:0] wr_sel;
  logic [NUM_CH-1:0] inc_nz;
  logic [NUM_CH-1:0] inc_nz_next;
  logic [ACC_W-1:0]  load_val;

  lock_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             locked_q, locked_d;

  // Writes to a channel index beyond NUM_CH still consume the handshake but change nothing.
  assign accept = cfg.cfg_valid & ready_q;
  assign wr_en  = accept && (int'(cfg.cfg_ch) < NUM_CH);

`ifdef FRAC_DIV_PHASE_EN
  assign load_val = cfg.cfg_phase;
`else
  assign load_val = '0;
`endif

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    wr_sel = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      wr_sel[i] = wr_en && (int'(cfg.cfg_ch) == i);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge refclk) begin
    if (rst) begin
      ready_q <= 1'b0;
    end else begin
      ready_q <= ~accept;
    end
  end

  assign cfg.cfg_ready = ready_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] inc_q;
    logic             tick_q;
    logic [ACC_W:0]   sum;

    assign sum = {1'b0, acc_q} + {1'b0, inc_q};

    // NOTE: these per-channel registers are real state with defined reset values, not a RAM, so they are reset.
    always_ff @(posedge refclk) begin
      if (rst) begin
        acc_q  <= '0;
        inc_q  <= INIT_INC;
        tick_q <= 1'b0;
      end else if (wr_sel[i]) begin
        acc_q  <= load_val;
        inc_q  <= cfg.cfg_inc;
        tick_q <= 1'b0;
      end else begin
        acc_q  <= sum[ACC_W-1:0];
        tick_q <= sum[ACC_W];
      end
    end

    assign outclk[i]      = acc_q[ACC_W-1];
    assign tick[i]        = tick_q;
    assign inc_nz[i]      = |inc_q;
    assign inc_nz_next[i] = wr_sel[i] ? (|cfg.cfg_inc) : (|inc_q);
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q  <= ST_SETTLE;
      cnt_q    <= '0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      locked_q <= locked_d;
    end
  end

  // A valid write restarts settling from any state; it also wins over a counter about to complete.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    locked_d = locked_q;
    if (wr_en) begin
      state_d  = (|inc_nz_next) ? ST_SETTLE : ST_HOLD;
      cnt_d    = '0;
      locked_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_HOLD: begin
          cnt_d    = '0;
          locked_d = 1'b0;
          if (|inc_nz) state_d = ST_SETTLE;
        end
        ST_SETTLE: begin
          if (cnt_q == CNT_LAST) begin
            state_d  = ST_LOCKED;
            locked_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_LOCKED: begin
          locked_d = 1'b1;
        end
        default: begin
          state_d  = ST_SETTLE;
          cnt_d    = '0;
          locked_d = 1'b0;
        end
      endcase
    end
  end

  assign locked = locked_q;

  a_ready_bubble: assert property (@(posedge refclk) disable iff (rst) accept |=> !cfg.cfg_ready);
  a_locked_state: assert property (@(posedge refclk) disable iff (rst) locked_q == (state_q == ST_LOCKED));
  a_cnt_range:    assert property (@(posedge refclk) disable iff (rst) cnt_q <= CNT_LAST);

endmodule
